// File: rtl/alu_pkg.sv
// Shared definitions for the ALU shift unit: op encodings, the per-stage
// control bundle and a constant log2 helper.
package alu_pkg;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_ROR = 2'b10;
  localparam logic [1:0] SH_SRA = 2'b11;

  // Control carried alongside the data; sign is the original operand MSB.
  typedef struct packed {
    logic [1:0] op;
    logic       sign;
  } shctl_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered stage of the log shifter: applies levels LO..HI of the
// shift/rotate, then registers the partial result with its control fields.
module shift_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int LO    = 0,
  parameter int HI    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             vld,
  input  shctl_t           ctl,
  input  logic [SHW-1:0]   amt,
  input  logic [WIDTH-1:0] d,
  output logic             q_vld,
  output shctl_t           q_ctl,
  output logic [SHW-1:0]   q_amt,
  output logic [WIDTH-1:0] q_d,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = d;
    for (int k = LO; k <= HI; k++) begin
      if (amt[k]) begin
        case (ctl.op)
          SH_SLL:  nxt = nxt << (1 << k);
          SH_SRL:  nxt = nxt >> (1 << k);
          // Fill comes from the carried sign, not the partial result's MSB.
          SH_SRA:  nxt = (nxt >> (1 << k)) |
                         (ctl.sign ? ~({WIDTH{1'b1}} >> (1 << k)) : '0);
          default: nxt = (nxt >> (1 << k)) | (nxt << (WIDTH - (1 << k)));
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_vld <= 1'b0;
      q_ctl <= '0;
      q_amt <= '0;
      q_d   <= '0;
    end else if (advance) begin
      q_vld <= vld;
      q_ctl <= ctl;
      q_amt <= amt;
      q_d   <= nxt;
    end
  end

endmodule

// File: rtl/alu_shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshake,
// whole-pipeline stall and a registered zero flag.
module alu_shift_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_zero
);

  localparam int SHW = clog2(WIDTH);

  logic                           advance;
  logic [STAGES:0]                vld_pipe;
  shctl_t [STAGES:0]              ctl_pipe;
  logic [STAGES:0][SHW-1:0]       amt_pipe;
  logic [STAGES:0][WIDTH-1:0]     d_pipe;
  logic [STAGES-1:0][WIDTH-1:0]   nxt_pipe;
  logic                           unused_bits;

  // The whole pipe moves together; an empty output slot never blocks.
  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;

  assign vld_pipe[0] = in_valid;
  assign ctl_pipe[0] = '{op: in_op, sign: in_b[WIDTH-1]};
  assign amt_pipe[0] = in_a[SHW-1:0];
  assign d_pipe[0]   = in_b;

  generate
    for (genvar s = 0; s < STAGES; s++) begin : g_stg
      // Level k lands in stage floor(k*STAGES/SHW).
      localparam int LO = (s * SHW + STAGES - 1) / STAGES;
      localparam int HI = ((s + 1) * SHW + STAGES - 1) / STAGES - 1;

      shift_stage #(
        .WIDTH(WIDTH),
        .SHW  (SHW),
        .LO   (LO),
        .HI   (HI)
      ) u_stage (
        .clk    (clk),
        .reset  (reset),
        .advance(advance),
        .vld    (vld_pipe[s]),
        .ctl    (ctl_pipe[s]),
        .amt    (amt_pipe[s]),
        .d      (d_pipe[s]),
        .q_vld  (vld_pipe[s+1]),
        .q_ctl  (ctl_pipe[s+1]),
        .q_amt  (amt_pipe[s+1]),
        .q_d    (d_pipe[s+1]),
        .nxt    (nxt_pipe[s])
      );
    end
  endgenerate

  // Zero flag is computed from the last stage's input so it lands with out_s.
  always_ff @(posedge clk) begin
    if (reset)        out_zero <= 1'b0;
    else if (advance) out_zero <= (nxt_pipe[STAGES-1] == '0);
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_s     = d_pipe[STAGES];

  assign unused_bits = ^{in_a[WIDTH-1:SHW], ctl_pipe[STAGES], amt_pipe[STAGES], nxt_pipe};

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Bench for alu_shift_pipe: four configurations against a bit-level model,
// plus directed vectors with hand-computed results on the 32x2 instance.
module tb_alu_shift_pipe;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] s;
    int          cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        v, r;
  logic [31:0]       in_a, in_b;
  logic [1:0]        in_op;
  logic [3:0]        i_ready, o_valid, o_zero;
  logic [3:0][31:0]  o_s;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          done = 0;
  int          consumed[4];
  exp_t        sb[4][$];
  logic [31:0] log0[$];

  always #5 clk = ~clk;

  function automatic int wid(input int g);
    return (g == 3) ? 8 : 32;
  endfunction

  function automatic int stg(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      2:       return 5;
      default: return 3;
    endcase
  endfunction

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int W = (g == 3) ? 8 : 32;
      localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 5 : 3;
      logic [W-1:0] s_w;
      alu_shift_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (v[g]),
        .in_ready (i_ready[g]),
        .in_a     (in_a[W-1:0]),
        .in_b     (in_b[W-1:0]),
        .in_op    (in_op),
        .out_valid(o_valid[g]),
        .out_ready(r[g]),
        .out_s    (s_w),
        .out_zero (o_zero[g])
      );
      assign o_s[g] = 32'(s_w);
    end
  endgenerate

  // Bitwise definition of each mode over a w-bit operand.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
    int n;
    logic [31:0] res;
    n   = int'(a & 32'(w - 1));
    res = '0;
    for (int i = 0; i < w; i++) begin
      case (op)
        SH_SLL:  res[i] = (i >= n) ? b[i-n] : 1'b0;
        SH_SRL:  res[i] = (i + n < w) ? b[i+n] : 1'b0;
        SH_SRA:  res[i] = (i + n < w) ? b[i+n] : b[w-1];
        default: res[i] = b[(i+n) % w];
      endcase
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    while (!done) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (reset) begin
          sb[g].delete();
        end else begin
          chk($sformatf("in_ready rule inst%0d", g), 32'(i_ready[g]), 32'(r[g] || !o_valid[g]));
          if (o_valid[g] && r[g]) begin
            if (sb[g].size() == 0) begin
              chk($sformatf("unexpected result inst%0d", g), 32'(o_valid[g]), 32'd0);
            end else begin
              e = sb[g].pop_front();
              chk($sformatf("data inst%0d", g), o_s[g], e.s);
              chk($sformatf("zero inst%0d", g), 32'(o_zero[g]), 32'(e.s == 0));
              if (g != 0) chk($sformatf("latency inst%0d", g), 32'(cyc - e.cyc), 32'(stg(g)));
              consumed[g]++;
              if (g == 0) log0.push_back(o_s[g]);
            end
          end
          if (v[g] && i_ready[g])
            sb[g].push_back('{s: ref_shift(in_op, in_a, in_b, wid(g)), cyc: cyc});
        end
      end
      cyc++;
    end
  endtask

  // Single op on instance 0 with an empty pipe; result must appear 2 cycles later.
  task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_s, input logic exp_z);
    in_op = op; in_a = a; in_b = b; v[0] = 1'b1;
    @(negedge clk) chk({name, " in_ready"}, 32'(i_ready[0]), 32'd1);
    @(posedge clk) #1 v[0] = 1'b0;
    @(negedge clk) chk({name, " early valid"}, 32'(o_valid[0]), 32'd0);
    @(negedge clk);
    chk({name, " valid"}, 32'(o_valid[0]), 32'd1);
    chk({name, " s"}, o_s[0], exp_s);
    chk({name, " zero"}, 32'(o_zero[0]), 32'(exp_z));
    @(posedge clk) #1;
  endtask

  // Present an op on instance 0 until accepted; leaves in_valid high.
  task automatic send0(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit acc;
    acc = 0;
    in_op = op; in_a = a; in_b = b; v[0] = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk) acc = i_ready[0];
      @(posedge clk) #1;
    end
    chk("send accept", 32'(acc), 32'd1);
  endtask

  task automatic stimulus();
    int c0;
    logic [31:0] bp_exp[4];
    // reset state
    @(posedge clk) #1;
    @(negedge clk);
    chk("reset out_valid", 32'(o_valid[0]), 32'd0);
    chk("reset out_s", o_s[0], 32'd0);
    chk("reset out_zero", 32'(o_zero[0]), 32'd0);
    @(posedge clk) #1 reset = 1'b0;
    @(negedge clk) chk("in_ready after reset", 32'(i_ready[0]), 32'd1);
    @(posedge clk) #1;

    directed("sll31", SH_SLL, 32'd31, 32'h0000_0001, 32'h8000_0000, 1'b0);
    directed("sra4", SH_SRA, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0);
    directed("srl4", SH_SRL, 32'd4, 32'h8000_0000, 32'h0800_0000, 1'b0);
    directed("ror1", SH_ROR, 32'd1, 32'h0000_0001, 32'h8000_0000, 1'b0);
    directed("ror masked", SH_ROR, 32'hFFFF_FFE4, 32'h1234_5678, 32'h8123_4567, 1'b0);
    directed("srl to zero", SH_SRL, 32'd1, 32'h0000_0001, 32'h0000_0000, 1'b1);
    directed("sra by 0", SH_SRA, 32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    directed("sll by 0 masked", SH_SLL, 32'h0000_0020, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0);

    // backpressure: 4 ops, out_ready low for 3 cycles once results start
    bp_exp = '{32'h0000_0008, 32'h00F0_0000, 32'hFF80_0000, 32'hABCD_0000};
    c0 = consumed[0];
    fork
      begin
        send0(SH_SLL, 32'd3, 32'h0000_0001);
        send0(SH_SRL, 32'd8, 32'hF000_0000);
        send0(SH_SRA, 32'd8, 32'h8000_0000);
        send0(SH_ROR, 32'd16, 32'h0000_ABCD);
        v[0] = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 r[0] = 1'b0;
        repeat (3) begin
          @(negedge clk) chk("stall in_ready", 32'(i_ready[0]), 32'd0);
          @(posedge clk) #1;
        end
        r[0] = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    chk("bp count", 32'(consumed[0] - c0), 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("bp order %0d", k), (c0 + k < log0.size()) ? log0[c0+k] : 32'hxxxx_xxxx, bp_exp[k]);

    // reset with two ops in flight; a third op is offered during reset
    send0(SH_SLL, 32'd2, 32'h0000_0001);
    send0(SH_SRA, 32'd1, 32'h8000_0000);
    reset = 1'b1;
    in_op = SH_SRL; in_a = 32'd1; in_b = 32'h0000_0100;
    @(posedge clk) #1;
    reset = 1'b0; v[0] = 1'b0;
    @(negedge clk);
    chk("midreset out_valid", 32'(o_valid[0]), 32'd0);
    chk("midreset out_s", o_s[0], 32'd0);
    chk("midreset in_ready", 32'(i_ready[0]), 32'd1);
    c0 = consumed[0];
    repeat (6) @(posedge clk);
    #1;
    chk("no stale after reset", 32'(consumed[0] - c0), 32'd0);

    // random sweep across all configurations
    for (int t = 0; t < 400; t++) begin
      v     = 4'($urandom);
      r     = {3'b111, ($urandom_range(3) != 0)};
      in_op = 2'($urandom);
      in_a  = $urandom;
      case ($urandom_range(3))
        0:       in_b = 32'd0;
        1:       in_b = 32'h8000_0000 | ($urandom & 32'h0000_00FF);
        default: in_b = $urandom;
      endcase
      @(posedge clk) #1;
    end
    v = 4'd0; r = 4'hF;
    repeat (12) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("drained inst%0d", g), 32'(sb[g].size()), 32'd0);
      chk($sformatf("activity inst%0d", g), 32'(consumed[g] > 20), 32'd1);
    end
    done = 1;
  endtask

  initial begin
    reset = 1'b1; v = 4'd0; r = 4'hF;
    in_a = '0; in_b = '0; in_op = SH_SLL;
    for (int g = 0; g < 4; g++) consumed[g] = 0;
    fork
      monitor();
      stimulus();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/alu_shift_pipe.md
# alu_shift_pipe

Pipelined, parametrised barrel shifter. It is the next-generation shift unit for the ALU and is used by the pipelined CPU datapath in place of the single-cycle combinational shifter. Compared with that shifter it adds:
- configurable data width and pipeline depth;
- a rotate-right mode;
- a valid/ready handshake with full backpressure;
- a zero flag on the result.

## Interface
Parameters:
- `WIDTH`, default 32: data width; must be a power of two, at least 4.
- `STAGES`, default 2: number of registered pipeline stages; legal range 1..log2(WIDTH).

Derived constant (not overridable):
- `SHW` = log2(WIDTH): shift-amount width.

Ports (name, direction, width, meaning):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  an operation is presented this cycle.
- `in_ready`  out  1  the block accepts an operation this cycle.
- `in_a`  in  WIDTH  shift amount; only `in_a[SHW-1:0]` is used, upper bits are ignored.
- `in_b`  in  WIDTH  operand to be shifted.
- `in_op`  in  2  operation select: 00 SLL, 01 SRL, 11 SRA, 10 ROR (rotate right).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_s`  out  WIDTH  result.
- `out_zero`  out  1  high when `out_s == 0`; qualified by `out_valid`.

## Operation
- Transfer rules:
  - An input is accepted when `in_valid && in_ready`.
  - An output is consumed when `out_valid && out_ready`.
- Shift amount `n = in_a[SHW-1:0]`, range 0..WIDTH-1. A shift of 0 returns `in_b` unchanged in every mode.
- Mode definitions:
  - SLL: `b << n`, zero fill.
  - SRL: `b >> n`, zero fill.
  - SRA: `b >> n`, filled with `b[WIDTH-1]`.
  - ROR: bit i of the result is `b[(i+n) mod WIDTH]`.
- Log-shifter implementation:
  - There are SHW levels; level k conditionally shifts or rotates by 2^k under `n[k]`.
  - Level k belongs to stage `floor(k*STAGES/SHW)`.
  - Each stage registers its partial result plus the carried `op`, the remaining shift-amount bits and a valid bit.
- SRA sign fill uses the original `b[WIDTH-1]`, carried through the stages. It is not re-read from the partial result.
- Stall model (whole pipeline, no bubble collapse):
  - `advance = out_ready || !out_valid`.
  - `in_ready = advance`.
  - When `advance` is low, every stage register holds its value.
  - When `advance` is high, every stage loads from its predecessor. Stage 0 loads `in_valid` and the operands; a non-accepted cycle loads valid=0.
- `out_s` and `out_zero` come directly from the last stage registers. `out_zero` is registered alongside `out_s`, so there is no combinational path from inputs to outputs.
- Results leave in acceptance order; none are dropped or duplicated.

## Timing
- Latency: a result accepted at edge t is visible at `out_valid` after edge t+STAGES-1, provided there is no stall. With STAGES=1, the result is valid in the cycle after acceptance.
- Throughput: one operation per cycle while `out_ready` is high.
- A stall lasting m cycles delays every in-flight result by exactly m cycles.
- `in_ready` depends combinationally on `out_ready` and `out_valid` only; it must never depend on `in_valid`.
- Reset, synchronous:
  - All stage valid bits, data registers and `out_zero` clear to 0.
  - `out_valid` = 0 and `out_s` = 0 after the reset edge.
  - `in_ready` = 1 in the cycle after reset (`out_valid` is 0).
- Reset asserted mid-operation discards all in-flight results. An input presented during a reset cycle is not accepted.
- Simultaneous consume at the output and accept at the input in the same cycle is legal and loses nothing.
- `in_valid` high while `in_ready` is low: the input is not captured, and the source must hold it.

## Structure
- Shared package `alu_pkg`:
  - op encodings `SH_SLL = 2'b00`, `SH_SRL = 2'b01`, `SH_ROR = 2'b10`, `SH_SRA = 2'b11`;
  - a `clog2`-style helper for SHW.
- Sub-module `shift_stage`: one registered stage, parametrised by WIDTH and by the first and last level it performs. It has pass-through valid/op/sign/amount fields and a common `advance` enable.
- The top level instantiates STAGES copies in a generate loop, plus the handshake logic and the zero-flag register.

## Test plan
All scenarios use WIDTH=32, STAGES=2 unless noted.
- SLL: `b=0x00000001`, `a=31` → `out_s=0x80000000`, `out_zero=0`, valid 2 cycles after acceptance.
- SRA vs SRL: `b=0x80000000`, `a=4` → SRA gives `0xF8000000`; SRL gives `0x08000000`.
- ROR and masking:
  - `b=0x00000001`, `a=1` → `0x80000000`.
  - `a=0xFFFFFFE4` is used as n=4, so `b=0x12345678` → `0x81234567`.
  - `b=0x00000001`, SRL, `a=1` → `0x00000000` with `out_zero=1`.
- Backpressure:
  - Send 4 back-to-back ops while holding `out_ready` low for 3 cycles mid-stream.
  - Required: `in_ready` low during the stall, all 4 results appear in order, no loss and no duplicates.
- Reset mid-flight: reset with 2 ops in flight → `out_valid=0` and `out_s=0` after the reset edge, no stale result appears afterwards, and `in_ready=1` in the cycle after reset.
- Sweep STAGES=1 and STAGES=5, plus WIDTH=8, with random ops compared against a reference model → all results match, and latency equals STAGES.
